stopwatch_sequencer: RTL and testbench

Control sequencer for the stopwatch seconds/minutes counter datapath. It turns raw start/stop/reset/lap button levels into single presses and generates the 1 Hz count-enable pulse from the system clock. It runs the run/pause/lap state machine, drives counter clear, freezes the display for lap splits, and halts counting at the 120:00 limit. It replaces the free-running enable path feeding the seconds counter.

---
 rtl/stopwatch_pkg.sv | 30 +++
 rtl/stopwatch_sequencer_tick_prescaler.sv | 47 ++++
 rtl/stopwatch_sequencer.sv | 155 +++++++++++++++
 tb/tb_stopwatch_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared encodings and widths for the stopwatch control sequencer.
package stopwatch_pkg;

    localparam int MIN_W           = 8;
    localparam int SEC_W           = 6;
    localparam int MAX_MIN_DEFAULT = 120;

    localparam logic [1:0] STATUS_IDLE    = 2'b00;
    localparam logic [1:0] STATUS_RUNNING = 2'b01;
    localparam logic [1:0] STATUS_PAUSED  = 2'b10;
    localparam logic [1:0] STATUS_LAP     = 2'b11;

    // Bit positions of the buttons inside the packed button vector.
    localparam int BTN_LAP   = 0;
    localparam int BTN_START = 1;
    localparam int BTN_STOP  = 2;
    localparam int BTN_RESET = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = STATUS_IDLE,
        ST_RUNNING = STATUS_RUNNING,
        ST_PAUSED  = STATUS_PAUSED,
        ST_LAP     = STATUS_LAP
    } state_e;

    function automatic logic is_counting(input state_e s);
        return (s == ST_RUNNING) || (s == ST_LAP);
    endfunction

endpackage

// File: rtl/stopwatch_sequencer_tick_prescaler.sv
// Divides the system clock down to one tick per counted second; the count
// holds while run is low so a paused fractional second is preserved.
module tick_prescaler #(
    parameter int TICK_DIV = 100000000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int              CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count and wrap tick.
    always_comb begin
        count_d = count_q;
        tick    = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (run) begin
            if (count_q == LAST) begin
                count_d = '0;
                tick    = 1'b1;
            end else begin
                count_d = count_q + ONE;
            end
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/stopwatch_sequencer.sv
// Stopwatch control: button press detection, run/pause/lap FSM, 1 Hz count
// enable, counter clear, lap capture and halt at the MAX_MIN:00 limit.
module stopwatch_sequencer
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 100000000,
    parameter int MAX_MIN  = MAX_MIN_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_btn,
    input  logic             stop_btn,
    input  logic             reset_btn,
    input  logic             lap_btn,
    input  logic [MIN_W-1:0] cnt_minutes,
    input  logic [SEC_W-1:0] cnt_seconds,
    output logic             cnt_enable,
    output logic             cnt_clear,
    output logic [MIN_W-1:0] disp_minutes,
    output logic [SEC_W-1:0] disp_seconds,
    output logic [MIN_W-1:0] lap_minutes,
    output logic [SEC_W-1:0] lap_seconds,
    output logic             lap_valid,
    output logic             max_reached,
    output logic [1:0]       status
);

    logic [3:0]       btn_s, press_s, prev_q, prev_d;
    state_e           state_q, state_d;
    logic [MIN_W-1:0] lap_min_q, lap_min_d, disp_min_q, disp_min_d;
    logic [SEC_W-1:0] lap_sec_q, lap_sec_d, disp_sec_q, disp_sec_d;
    logic             lap_valid_q, lap_valid_d, max_q, max_d;
    logic             clear_q, clear_d, enable_q, enable_d;
    logic             presc_run_s, presc_clear_s, tick_s, at_max_s;

    assign btn_s    = {reset_btn, stop_btn, start_btn, lap_btn};
    assign at_max_s = (cnt_minutes == MIN_W'(MAX_MIN)) && (cnt_seconds == '0);

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .run   (presc_run_s),
        .clear (presc_clear_s),
        .tick  (tick_s)
    );

    // The limit suppresses the enable even if a wrap lands on the same edge.
    assign enable_d = tick_s & ~at_max_s;

    // Press detection, state transitions and next values of all registered outputs.
    always_comb begin
        prev_d        = btn_s;
        press_s       = btn_s & ~prev_q;
        state_d       = state_q;
        lap_min_d     = lap_min_q;
        lap_sec_d     = lap_sec_q;
        lap_valid_d   = lap_valid_q;
        max_d         = max_q;
        clear_d       = 1'b0;
        presc_clear_s = 1'b0;
        if (press_s[BTN_RESET]) begin
            state_d       = ST_IDLE;
            clear_d       = 1'b1;
            presc_clear_s = 1'b1;
            lap_min_d     = '0;
            lap_sec_d     = '0;
            lap_valid_d   = 1'b0;
            max_d         = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (press_s[BTN_START]) begin
                        state_d       = ST_RUNNING;
                        presc_clear_s = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUNNING, ST_LAP: begin
                    if (at_max_s) begin
                        state_d = ST_PAUSED;
                        max_d   = 1'b1;
                    end else if (press_s[BTN_STOP]) begin
                        state_d = ST_PAUSED;
                    end else if (press_s[BTN_LAP]) begin
                        state_d     = (state_q == ST_LAP) ? ST_RUNNING : ST_LAP;
                        lap_min_d   = cnt_minutes;
                        lap_sec_d   = cnt_seconds;
                        lap_valid_d = 1'b1;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_PAUSED: begin
                    if (press_s[BTN_START] && !max_q) begin
                        state_d = ST_RUNNING;
                    end else begin
                        state_d = ST_PAUSED;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        // Only advance across edges that stay in a counting state, so the
        // fractional second is neither lost nor gained on pause/resume.
        presc_run_s = is_counting(state_q) && is_counting(state_d);
        if (state_d == ST_LAP) begin
            disp_min_d = lap_min_d;
            disp_sec_d = lap_sec_d;
        end else begin
            disp_min_d = cnt_minutes;
            disp_sec_d = cnt_seconds;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q      <= 4'b1111;
            state_q     <= ST_IDLE;
            lap_min_q   <= '0;
            lap_sec_q   <= '0;
            lap_valid_q <= 1'b0;
            max_q       <= 1'b0;
            clear_q     <= 1'b0;
            enable_q    <= 1'b0;
            disp_min_q  <= '0;
            disp_sec_q  <= '0;
        end else begin
            prev_q      <= prev_d;
            state_q     <= state_d;
            lap_min_q   <= lap_min_d;
            lap_sec_q   <= lap_sec_d;
            lap_valid_q <= lap_valid_d;
            max_q       <= max_d;
            clear_q     <= clear_d;
            enable_q    <= enable_d;
            disp_min_q  <= disp_min_d;
            disp_sec_q  <= disp_sec_d;
        end
    end

    assign cnt_enable   = enable_q;
    assign cnt_clear    = clear_q;
    assign disp_minutes = disp_min_q;
    assign disp_seconds = disp_sec_q;
    assign lap_minutes  = lap_min_q;
    assign lap_seconds  = lap_sec_q;
    assign lap_valid    = lap_valid_q;
    assign max_reached  = max_q;
    assign status       = state_q;

endmodule

// File: tb/tb_stopwatch_sequencer.sv
// Scoreboard bench for stopwatch_sequencer with TICK_DIV = 4: stimulus queues
// expected values by cycle, a negedge monitor pops and compares them.
module tb_stopwatch_sequencer;
    import stopwatch_pkg::*;

    localparam int TICK_DIV = 4;
    localparam int MAX_MIN  = 120;

    logic             clk = 1'b0;
    logic             rst, start_btn, stop_btn, reset_btn, lap_btn;
    logic [MIN_W-1:0] cnt_minutes, disp_minutes, lap_minutes;
    logic [SEC_W-1:0] cnt_seconds, disp_seconds, lap_seconds;
    logic             cnt_enable, cnt_clear, lap_valid, max_reached;
    logic [1:0]       status;

    stopwatch_sequencer #(.TICK_DIV(TICK_DIV), .MAX_MIN(MAX_MIN)) dut (
        .clk(clk), .rst(rst),
        .start_btn(start_btn), .stop_btn(stop_btn), .reset_btn(reset_btn), .lap_btn(lap_btn),
        .cnt_minutes(cnt_minutes), .cnt_seconds(cnt_seconds),
        .cnt_enable(cnt_enable), .cnt_clear(cnt_clear),
        .disp_minutes(disp_minutes), .disp_seconds(disp_seconds),
        .lap_minutes(lap_minutes), .lap_seconds(lap_seconds),
        .lap_valid(lap_valid), .max_reached(max_reached), .status(status)
    );

    always #5 clk = ~clk;

    typedef enum int {F_STATUS, F_DISP_MIN, F_DISP_SEC, F_LAP_MIN, F_LAP_SEC, F_LAP_VALID, F_MAX} field_e;
    typedef struct { int cyc; field_e fld; int val; } exp_t;

    exp_t exp_q[$];
    int   en_q[$];
    int   clr_q[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int actual(input field_e f);
        case (f)
            F_STATUS:    return int'(status);
            F_DISP_MIN:  return int'(disp_minutes);
            F_DISP_SEC:  return int'(disp_seconds);
            F_LAP_MIN:   return int'(lap_minutes);
            F_LAP_SEC:   return int'(lap_seconds);
            F_LAP_VALID: return int'(lap_valid);
            default:     return int'(max_reached);
        endcase
    endfunction

    // Monitor: field expectations due this cycle, plus exact pulse timing.
    always @(negedge clk) begin
        exp_t e;
        int   tmp;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (e.cyc < cyc) begin
                n_fail++;
                $display("FAIL %s cyc %0d: not sampled, expected %0d", e.fld.name(), e.cyc, e.val);
            end else if (actual(e.fld) != e.val) begin
                n_fail++;
                $display("FAIL %s cyc %0d: got %0d expected %0d", e.fld.name(), cyc, actual(e.fld), e.val);
            end
        end
        if (en_q.size() > 0 && en_q[0] < cyc) begin
            n_cmp++; n_fail++;
            tmp = en_q.pop_front();
            $display("FAIL cnt_enable cyc %0d: got 0 expected 1", tmp);
        end
        if (cnt_enable) begin
            n_cmp++;
            if (en_q.size() > 0 && en_q[0] == cyc) begin
                tmp = en_q.pop_front();
            end else begin
                n_fail++;
                $display("FAIL cnt_enable cyc %0d: got 1 expected 0", cyc);
            end
        end
        if (clr_q.size() > 0 && clr_q[0] < cyc) begin
            n_cmp++; n_fail++;
            tmp = clr_q.pop_front();
            $display("FAIL cnt_clear cyc %0d: got 0 expected 1", tmp);
        end
        if (cnt_clear) begin
            n_cmp++;
            if (clr_q.size() > 0 && clr_q[0] == cyc) begin
                tmp = clr_q.pop_front();
            end else begin
                n_fail++;
                $display("FAIL cnt_clear cyc %0d: got 1 expected 0", cyc);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_f(input field_e f, input int v, input int at);
        exp_t e;
        e.cyc = at; e.fld = f; e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic set_cnt(input int m, input int s);
        cnt_minutes = MIN_W'(m);
        cnt_seconds = SEC_W'(s);
    endtask

    task automatic release_all();
        start_btn = 1'b0; stop_btn = 1'b0; reset_btn = 1'b0; lap_btn = 1'b0;
    endtask

    initial begin
        int e, r, l, r2, t;
        rst = 1'b1;
        release_all();
        set_cnt(0, 0);
        step(2);
        expect_f(F_STATUS, 0, cyc); expect_f(F_DISP_MIN, 0, cyc);
        expect_f(F_LAP_VALID, 0, cyc); expect_f(F_MAX, 0, cyc);
        rst = 1'b0;
        step(3);
        expect_f(F_STATUS, 0, cyc);

        // Start: enable pulses 4, 8, 12 cycles after entry.
        start_btn = 1'b1;
        e = cyc + 1;
        expect_f(F_STATUS, 1, e);
        en_q.push_back(e + 4); en_q.push_back(e + 8); en_q.push_back(e + 12);
        step(1); release_all();
        step(14);
        // Prescaler is 2 here; pause for 20 cycles, then resume.
        stop_btn = 1'b1;
        expect_f(F_STATUS, 2, cyc + 1);
        step(1); release_all();
        step(20);
        expect_f(F_STATUS, 2, cyc);
        start_btn = 1'b1;
        r = cyc + 1;
        expect_f(F_STATUS, 1, r);
        en_q.push_back(r + 2); en_q.push_back(r + 6);
        step(1); release_all();

        // Lap at 1:05, display frozen while counters advance, second lap at 1:09.
        step(3);
        set_cnt(1, 5);
        lap_btn = 1'b1;
        l = cyc + 1;
        expect_f(F_STATUS, 3, l); expect_f(F_LAP_VALID, 1, l);
        expect_f(F_LAP_MIN, 1, l); expect_f(F_LAP_SEC, 5, l);
        expect_f(F_DISP_MIN, 1, l); expect_f(F_DISP_SEC, 5, l);
        step(1); release_all(); set_cnt(1, 6);
        step(1);
        expect_f(F_STATUS, 3, cyc); expect_f(F_DISP_SEC, 5, cyc);
        set_cnt(1, 9);
        step(1);
        expect_f(F_DISP_SEC, 5, cyc);
        lap_btn = 1'b1;
        expect_f(F_STATUS, 1, cyc + 1); expect_f(F_LAP_MIN, 1, cyc + 1);
        expect_f(F_LAP_SEC, 9, cyc + 1); expect_f(F_DISP_SEC, 9, cyc + 1);
        expect_f(F_LAP_VALID, 1, cyc + 1);
        step(1); release_all(); set_cnt(1, 10);
        step(1);
        expect_f(F_DISP_SEC, 10, cyc);

        // Stop and lap together: stop wins, lap registers untouched.
        stop_btn = 1'b1; lap_btn = 1'b1;
        expect_f(F_STATUS, 2, cyc + 1); expect_f(F_LAP_MIN, 1, cyc + 1);
        expect_f(F_LAP_SEC, 9, cyc + 1); expect_f(F_LAP_VALID, 1, cyc + 1);
        step(1); release_all();

        // Limit: 120:00 reached just as the prescaler would wrap.
        step(2);
        set_cnt(119, 59);
        start_btn = 1'b1;
        r2 = cyc + 1;
        expect_f(F_STATUS, 1, r2); expect_f(F_MAX, 0, r2);
        step(1); release_all();
        step(1);
        set_cnt(MAX_MIN, 0);
        expect_f(F_STATUS, 2, r2 + 2); expect_f(F_MAX, 1, r2 + 2);
        step(3);
        start_btn = 1'b1;
        expect_f(F_STATUS, 2, cyc + 1); expect_f(F_MAX, 1, cyc + 1);
        step(1); release_all();
        step(1);
        expect_f(F_STATUS, 2, cyc);
        reset_btn = 1'b1;
        expect_f(F_STATUS, 0, cyc + 1); expect_f(F_MAX, 0, cyc + 1);
        expect_f(F_LAP_VALID, 0, cyc + 1); expect_f(F_LAP_MIN, 0, cyc + 1);
        expect_f(F_LAP_SEC, 0, cyc + 1);
        clr_q.push_back(cyc + 1);
        step(1); release_all(); set_cnt(0, 0);
        step(1);
        expect_f(F_STATUS, 0, cyc);

        // Start held through rst gives no press after release of rst.
        t = cyc;
        start_btn = 1'b1; rst = 1'b1;
        step(2);
        expect_f(F_STATUS, 0, cyc); expect_f(F_LAP_VALID, 0, cyc); expect_f(F_DISP_MIN, 0, cyc);
        rst = 1'b0;
        step(1);
        expect_f(F_STATUS, 0, cyc);
        step(1);
        start_btn = 1'b0;
        expect_f(F_STATUS, 0, cyc);
        step(2);
        expect_f(F_STATUS, 0, cyc);
        start_btn = 1'b1;
        expect_f(F_STATUS, 1, t + 7);
        step(1); release_all();
        step(1);
        // Reset and start together while running: reset wins.
        reset_btn = 1'b1; start_btn = 1'b1;
        expect_f(F_STATUS, 0, t + 9);
        clr_q.push_back(t + 9);
        step(1); release_all();
        step(6);
        expect_f(F_STATUS, 0, cyc);
        step(2);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL exp_queue_drain: got %0d pending expected 0", exp_q.size());
        end
        n_cmp++;
        if (en_q.size() != 0) begin
            n_fail++;
            $display("FAIL enable_queue_drain: got %0d pending expected 0", en_q.size());
        end
        n_cmp++;
        if (clr_q.size() != 0) begin
            n_fail++;
            $display("FAIL clear_queue_drain: got %0d pending expected 0", clr_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
